// File: rtl/aes_encrypt_engine_cfg.sv
// Iterative AES encryption engine with run-time key length (128/192/256).
// The key schedule is expanded once per key load into a word store, then each
// block runs one round per cycle through a shared round datapath.
module aes_encrypt_engine_cfg #(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_key,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         key_ready,
  output logic         key_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  input  logic         halt,
  output logic         busy
);

  localparam int unsigned NR_MAX = MAX_KEY_BITS / 32 + 6;
  localparam int unsigned NW     = 4 * (NR_MAX + 1);
  localparam int unsigned WIDX_W = $clog2(NW);
  localparam int unsigned RND_W  = 4;

  typedef enum logic [2:0] {IDLE, KEY_EXP, READY, RUN, HOLD} state_t;

  // GF(2^8) multiply by x modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) general multiply
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  // S-box: inverse followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One cipher round; MixColumns bypassed on the final round
  function automatic logic [127:0] aes_round(input logic [127:0] s_in,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s_in[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  state_t              state_q, state_d;
  logic [31:0]         w_q [NW];
  logic [WIDX_W-1:0]   widx_q;
  logic [2:0]          kmod_q;
  logic [7:0]          rcon_q;
  logic [1:0]          klen_q;
  logic [127:0]        st_q;
  logic [RND_W-1:0]    rnd_q;
  logic                fin_q;

  logic                load_key, exp_step, accept, round_step, finish, zeroize;
  logic                key_err_d, key_ready_d, in_ready_d, out_valid_d, busy_d;
  logic                key_legal_c;
  logic [WIDX_W-1:0]   nk_c, last_widx_c, rk_base_c;
  logic [RND_W-1:0]    nr_c;
  logic [31:0]         prev_w, back_w, tmp_w, new_w;
  logic [127:0]        rk0_c, rkr_c;

  // Key geometry for the latched key length
  always_comb begin
    nk_c        = WIDX_W'(4) + WIDX_W'({klen_q, 1'b0});
    nr_c        = RND_W'(10) + RND_W'({klen_q, 1'b0});
    last_widx_c = WIDX_W'({nr_c, 2'b00}) + WIDX_W'(3);
    key_legal_c = (key_len != 2'd3) &&
                  ((32'd128 + 32'd64 * 32'(key_len)) <= 32'(MAX_KEY_BITS));
  end

  // Next schedule word w[i] from w[i-1] and w[i-Nk]
  always_comb begin
    prev_w = w_q[widx_q - WIDX_W'(1)];
    back_w = w_q[widx_q - nk_c];
    tmp_w  = prev_w;
    if (kmod_q == 3'd0)
      tmp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
    else if (nk_c == WIDX_W'(8) && kmod_q == 3'd4)
      tmp_w = sub_word(prev_w);
    new_w = back_w ^ tmp_w;
  end

  // Round-key selection: rk[0] for the whitening step, rk[r] for round r
  always_comb begin
    rk_base_c = WIDX_W'({rnd_q, 2'b00});
    rk0_c     = {w_q[0], w_q[1], w_q[2], w_q[3]};
    rkr_c     = {w_q[rk_base_c], w_q[rk_base_c + WIDX_W'(1)],
                 w_q[rk_base_c + WIDX_W'(2)], w_q[rk_base_c + WIDX_W'(3)]};
  end

  // Next-state and control decode; halt overrides everything but rst
  always_comb begin
    state_d    = state_q;
    load_key   = 1'b0;
    exp_step   = 1'b0;
    accept     = 1'b0;
    round_step = 1'b0;
    finish     = 1'b0;
    zeroize    = 1'b0;
    key_err_d  = key_err;
    if (halt) begin
      state_d = IDLE;
      zeroize = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (set_key) begin
            if (key_legal_c) begin
              load_key  = 1'b1;
              key_err_d = 1'b0;
              state_d   = KEY_EXP;
            end else begin
              key_err_d = 1'b1;
            end
          end
        end
        KEY_EXP: begin
          exp_step = 1'b1;
          if (widx_q == last_widx_c) state_d = READY;
        end
        READY: begin
          // A completed input handshake takes precedence over a re-key request
          if (in_valid) begin
            accept  = 1'b1;
            state_d = RUN;
          end else if (set_key) begin
            if (key_legal_c) begin
              load_key  = 1'b1;
              key_err_d = 1'b0;
              state_d   = KEY_EXP;
            end else begin
              key_err_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
        RUN: begin
          if (fin_q) begin
            finish  = 1'b1;
            state_d = HOLD;
          end else begin
            round_step = 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) state_d = READY;
        end
        default: state_d = IDLE;
      endcase
    end
    key_ready_d = (state_d == READY) || (state_d == RUN) || (state_d == HOLD);
    in_ready_d  = (state_d == READY);
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d == KEY_EXP) || (state_d == RUN) || out_valid_d;
  end

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_ready <= 1'b0;
      key_err   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_ready <= key_ready_d;
      key_err   <= key_err_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  // Key store, schedule counters and cipher state
  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
      widx_q   <= '0;
      kmod_q   <= '0;
      rcon_q   <= '0;
      klen_q   <= '0;
      st_q     <= '0;
      rnd_q    <= '0;
      fin_q    <= 1'b0;
      out_data <= '0;
    end else begin
      if (load_key) begin
        // Unused upper words are overwritten by the expansion before any read
        for (int k = 0; k < 8; k++) w_q[k] <= key[255-32*k -: 32];
        widx_q <= WIDX_W'(4) + WIDX_W'({key_len, 1'b0});
        kmod_q <= '0;
        rcon_q <= 8'h01;
        klen_q <= key_len;
      end
      if (exp_step) begin
        w_q[widx_q] <= new_w;
        if (widx_q != last_widx_c) widx_q <= widx_q + WIDX_W'(1);
        kmod_q <= (WIDX_W'(kmod_q) == nk_c - WIDX_W'(1)) ? 3'd0 : kmod_q + 3'd1;
        if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
      if (accept) begin
        st_q  <= in_data ^ rk0_c;
        rnd_q <= RND_W'(1);
        fin_q <= 1'b0;
      end
      if (round_step) begin
        st_q <= aes_round(st_q, rkr_c, rnd_q == nr_c);
        if (rnd_q == nr_c) fin_q <= 1'b1;
        else               rnd_q <= rnd_q + RND_W'(1);
      end
      if (finish) begin
        out_data <= st_q;
        fin_q    <= 1'b0;
      end
    end
  end

endmodule
